// File: rtl/dmem_pkg.sv
// Shared constants and sweep-state encoding for the data-memory responder.
package dmem_pkg;

   localparam int DMEM_DEPTH = 2048;
   localparam int DMEM_AW    = 11;
   localparam int DMEM_DW    = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } sweep_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-memory port, host preload/dump port and zero-fill control,
// bundled with master (requester) and slave (memory) views.
interface dmem_responder_if
   import dmem_pkg::*;
#(
   parameter int AW = DMEM_AW,
   parameter int DW = DMEM_DW
) ();

   logic          DM_Wena;
   logic          DM_Rena;
   logic [AW-1:0] DM_addr;
   logic [DW-1:0] DM_wdata;
   logic [DW-1:0] DM_rdata;

   logic          host_valid;
   logic          host_ready;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_rvalid;
   logic [DW-1:0] host_rdata;

   logic          clr_start;
   logic          clr_busy;
   logic          clr_done;
   logic          dm_err;

   modport slave (
      input  DM_Wena, DM_Rena, DM_addr, DM_wdata,
      output DM_rdata,
      input  host_valid, host_we, host_addr, host_wdata,
      output host_ready, host_rvalid, host_rdata,
      input  clr_start,
      output clr_busy, clr_done, dm_err
   );

   modport master (
      output DM_Wena, DM_Rena, DM_addr, DM_wdata,
      input  DM_rdata,
      output host_valid, host_we, host_addr, host_wdata,
      input  host_ready, host_rvalid, host_rdata,
      output clr_start,
      input  clr_busy, clr_done, dm_err
   );

endinterface

// File: rtl/dmem_array.sv
// Word storage: one arbitrated write port, an asynchronous CPU read port
// and a registered host read port that holds its last value.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH,
   parameter int AW    = DMEM_AW,
   parameter int DW    = DMEM_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_craddr,
   output logic [DW-1:0] o_crdata,
   input  logic          i_hre,
   input  logic [AW-1:0] i_hraddr,
   output logic [DW-1:0] o_hrdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_hrdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read-before-write: a host read colliding with a write sees the old word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hrdata <= '0;
      end else if (i_hre) begin
         r_hrdata <= r_mem[i_hraddr];
      end
   end

   assign o_crdata = r_mem[i_craddr];
   assign o_hrdata = r_hrdata;

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the CPU DM port with a lower-priority host port and a
// zero-fill sweep that yields to CPU traffic.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH,
   parameter int AW    = DMEM_AW,
   parameter int DW    = DMEM_DW
) (
   input  logic            clk,
   input  logic            rst,
   dmem_responder_if.slave bus
);

   sweep_state_e  r_state, w_state_next;
   logic [AW:0]   r_cnt, w_cnt_next;
   logic          r_dm_err;
   logic          r_host_rvalid;

   logic          w_cpu_busy;
   logic          w_host_ready;
   logic          w_host_rd;
   logic          w_sweep_wr;
   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic [DW-1:0] w_wdata;
   logic [DW-1:0] w_crdata;

   assign w_cpu_busy   = bus.DM_Wena | bus.DM_Rena;
   assign w_host_ready = bus.host_valid & ~w_cpu_busy & (r_state == IDLE) & ~rst;
   assign w_host_rd    = w_host_ready & ~bus.host_we;
   assign w_sweep_wr   = (r_state == CLEAR) & ~w_cpu_busy & ~rst;

   // Single write port, CPU > sweep > host.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = '0;
      w_wdata = '0;
      if (bus.DM_Wena) begin
         w_we    = 1'b1;
         w_waddr = bus.DM_addr;
         w_wdata = bus.DM_wdata;
      end else if (w_sweep_wr) begin
         w_we    = 1'b1;
         w_waddr = r_cnt[AW-1:0];
      end else if (w_host_ready & bus.host_we) begin
         w_we    = 1'b1;
         w_waddr = bus.host_addr;
         w_wdata = bus.host_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         IDLE: begin
            if (bus.clr_start) begin
               w_state_next = CLEAR;
               w_cnt_next   = '0;
            end
         end
         CLEAR: begin
            if (!w_cpu_busy) begin
               w_cnt_next = r_cnt + 1'b1;
               if (r_cnt == (AW+1)'(DEPTH - 1)) begin
                  w_state_next = DONE;
               end
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dm_err      <= 1'b0;
         r_host_rvalid <= 1'b0;
      end else begin
         r_dm_err      <= r_dm_err | (bus.DM_Wena & bus.DM_Rena);
         r_host_rvalid <= w_host_rd;
      end
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_we),
      .i_waddr  (w_waddr),
      .i_wdata  (w_wdata),
      .i_craddr (bus.DM_addr),
      .o_crdata (w_crdata),
      .i_hre    (w_host_rd),
      .i_hraddr (bus.host_addr),
      .o_hrdata (bus.host_rdata)
   );

   assign bus.DM_rdata    = bus.DM_Rena ? w_crdata : '0;
   assign bus.host_ready  = w_host_ready;
   assign bus.host_rvalid = r_host_rvalid;
   assign bus.clr_busy    = (r_state != IDLE);
   assign bus.clr_done    = (r_state == DONE);
   assign bus.dm_err      = r_dm_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: CPU, host, sweep, collision and reset-abort cases.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   busy_cnt;
   int   done_cnt;
   int   bad;

   dmem_responder_if #(.AW(DMEM_AW), .DW(DMEM_DW)) u_if ();

   dmem_responder #(
      .DEPTH (DMEM_DEPTH),
      .AW    (DMEM_AW),
      .DW    (DMEM_DW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit later, tallying sweep flags.
   task automatic tick();
      @(posedge clk);
      #1;
      if (u_if.clr_busy === 1'b1) busy_cnt++;
      if (u_if.clr_done === 1'b1) done_cnt++;
   endtask

   task automatic cpu_read(input logic [10:0] a, output logic [31:0] d);
      u_if.DM_Rena = 1'b1;
      u_if.DM_addr = a;
      #1;
      d = u_if.DM_rdata;
      u_if.DM_Rena = 1'b0;
   endtask

   task automatic cpu_write(input logic [10:0] a, input logic [31:0] d);
      u_if.DM_Wena  = 1'b1;
      u_if.DM_addr  = a;
      u_if.DM_wdata = d;
      tick();
      u_if.DM_Wena  = 1'b0;
   endtask

   task automatic host_write(input logic [10:0] a, input logic [31:0] d);
      bit ok;
      ok = 1'b0;
      u_if.host_valid = 1'b1;
      u_if.host_we    = 1'b1;
      u_if.host_addr  = a;
      u_if.host_wdata = d;
      for (int k = 0; k < 20 && !ok; k++) begin
         #1;
         if (u_if.host_ready === 1'b1) ok = 1'b1;
         tick();
      end
      u_if.host_valid = 1'b0;
      if (!ok) chk("host_write_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [31:0] d;
      n_cmp = 0; n_err = 0; busy_cnt = 0; done_cnt = 0;
      rst = 1'b1;
      u_if.DM_Wena = 1'b0; u_if.DM_Rena = 1'b0; u_if.DM_addr = '0; u_if.DM_wdata = '0;
      u_if.host_valid = 1'b0; u_if.host_we = 1'b0; u_if.host_addr = '0; u_if.host_wdata = '0;
      u_if.clr_start = 1'b0;
      tick(); tick();
      chk("rst_host_ready",  {31'd0, u_if.host_ready},  32'd0);
      chk("rst_host_rvalid", {31'd0, u_if.host_rvalid}, 32'd0);
      chk("rst_host_rdata",  u_if.host_rdata,           32'd0);
      chk("rst_clr_busy",    {31'd0, u_if.clr_busy},    32'd0);
      chk("rst_clr_done",    {31'd0, u_if.clr_done},    32'd0);
      chk("rst_dm_err",      {31'd0, u_if.dm_err},      32'd0);
      rst = 1'b0;
      tick();

      // CPU write then read; read gated by DM_Rena
      cpu_write(11'd5, 32'hDEADBEEF);
      u_if.DM_Rena = 1'b1; u_if.DM_addr = 11'd5; #1;
      chk("cpu_rd_5", u_if.DM_rdata, 32'hDEADBEEF);
      u_if.DM_Rena = 1'b0; #1;
      chk("cpu_rd_gated", u_if.DM_rdata, 32'd0);

      // Host write and read-back at top address
      u_if.host_valid = 1'b1; u_if.host_we = 1'b1;
      u_if.host_addr = 11'd2047; u_if.host_wdata = 32'h12345678; #1;
      chk("host_wr_ready", {31'd0, u_if.host_ready}, 32'd1);
      tick();
      u_if.host_we = 1'b0; #1;
      chk("host_rd_ready", {31'd0, u_if.host_ready}, 32'd1);
      chk("host_rvalid_pre", {31'd0, u_if.host_rvalid}, 32'd0);
      tick();
      u_if.host_valid = 1'b0;
      chk("host_rvalid", {31'd0, u_if.host_rvalid}, 32'd1);
      chk("host_rdata", u_if.host_rdata, 32'h12345678);
      tick();
      chk("host_rvalid_pulse", {31'd0, u_if.host_rvalid}, 32'd0);
      chk("host_rdata_hold", u_if.host_rdata, 32'h12345678);

      // Host request stalled by 3 CPU-busy cycles
      u_if.host_valid = 1'b1; u_if.host_we = 1'b1;
      u_if.host_addr = 11'd300; u_if.host_wdata = 32'hA5A50300;
      u_if.DM_Rena = 1'b1; u_if.DM_addr = 11'd0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("host_stall_%0d", k), {31'd0, u_if.host_ready}, 32'd0);
         tick();
      end
      u_if.DM_Rena = 1'b0; #1;
      chk("host_stall_accept", {31'd0, u_if.host_ready}, 32'd1);
      tick();
      u_if.host_valid = 1'b0;
      cpu_read(11'd300, d);
      chk("host_stall_data", d, 32'hA5A50300);

      // Fill all words nonzero, then sweep without CPU traffic
      for (int i = 0; i < DMEM_DEPTH; i++) host_write(11'(i), 32'h80000000 | i);
      cpu_read(11'd1234, d);
      chk("fill_1234", d, 32'h800004D2);
      busy_cnt = 0; done_cnt = 0;
      u_if.clr_start = 1'b1;
      tick();
      u_if.clr_start = 1'b0;
      for (int k = 0; k < 3000 && u_if.clr_busy === 1'b1; k++) tick();
      chk("sweep1_busy_cycles", busy_cnt, 32'd2049);
      chk("sweep1_done_pulses", done_cnt, 32'd1);
      bad = 0;
      for (int i = 0; i < DMEM_DEPTH; i++) begin
         cpu_read(11'(i), d);
         if (d !== 32'd0) bad++;
      end
      chk("sweep1_nonzero_words", bad, 32'd0);

      // Sweep with CPU writes at counter 100
      host_write(11'd1500, 32'h11110000);
      busy_cnt = 0; done_cnt = 0;
      u_if.clr_start = 1'b1;
      tick();
      u_if.clr_start = 1'b0;
      for (int k = 0; k < 100; k++) tick();
      cpu_write(11'd10, 32'hC0DE0010);
      cpu_write(11'd1500, 32'hC0DE1500);
      for (int k = 0; k < 3000 && u_if.clr_busy === 1'b1; k++) tick();
      chk("sweep2_busy_cycles", busy_cnt, 32'd2051);
      chk("sweep2_done_pulses", done_cnt, 32'd1);
      cpu_read(11'd10, d);
      chk("sweep2_addr10_kept", d, 32'hC0DE0010);
      cpu_read(11'd1500, d);
      chk("sweep2_addr1500_zero", d, 32'd0);

      // Simultaneous write+read on addr 7
      cpu_write(11'd7, 32'h1);
      u_if.DM_Wena = 1'b1; u_if.DM_Rena = 1'b1;
      u_if.DM_addr = 11'd7; u_if.DM_wdata = 32'h2; #1;
      chk("collide_old_data", u_if.DM_rdata, 32'h1);
      chk("collide_err_pre", {31'd0, u_if.dm_err}, 32'd0);
      tick();
      u_if.DM_Wena = 1'b0; #1;
      chk("collide_new_data", u_if.DM_rdata, 32'h2);
      chk("collide_err_set", {31'd0, u_if.dm_err}, 32'd1);
      u_if.DM_Rena = 1'b0;
      tick(); tick(); tick();
      chk("collide_err_sticky", {31'd0, u_if.dm_err}, 32'd1);

      // Reset clears dm_err; reset at counter 500 aborts a sweep
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_clears_err", {31'd0, u_if.dm_err}, 32'd0);
      host_write(11'd499, 32'h00000499);
      host_write(11'd600, 32'h00000600);
      busy_cnt = 0; done_cnt = 0;
      u_if.clr_start = 1'b1;
      tick();
      u_if.clr_start = 1'b0;
      for (int k = 0; k < 500; k++) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("abort_busy", {31'd0, u_if.clr_busy}, 32'd0);
      tick(); tick(); tick();
      chk("abort_no_done", done_cnt, 32'd0);
      cpu_read(11'd499, d);
      chk("abort_addr499_zero", d, 32'd0);
      cpu_read(11'd600, d);
      chk("abort_addr600_kept", d, 32'h00000600);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle MIPS core: the memory end of the CPU's DM port (DM_Wena/DM_Rena/DM_addr/DM_wdata/DM_rdata), holding 2048 32-bit words. It serves CPU reads combinationally and CPU writes on the clock edge. A lower-priority host port with a valid/ready handshake preloads and dumps memory for test. A sweep FSM zero-fills the array on command.

## Interface
Parameters:
- DEPTH, 2048, number of 32-bit words
- AW, 11, word-address width (log2 DEPTH)
- DW, 32, data width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- DM_Wena  in  1  CPU write enable
- DM_Rena  in  1  CPU read enable
- DM_addr  in  AW  CPU word address
- DM_wdata  in  DW  CPU write data
- DM_rdata  out  DW  CPU read data, combinational
- host_valid  in  1  host request valid
- host_ready  out  1  host request accepted this cycle
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host word address
- host_wdata  in  DW  host write data
- host_rvalid  out  1  host read data valid, one-cycle pulse
- host_rdata  out  DW  host read data, registered
- clr_start  in  1  start zero-fill sweep, pulse
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse when sweep finishes
- dm_err  out  1  registered flag: CPU asserted DM_Wena and DM_Rena together

## Operation
- CPU port always has top priority and never stalls.
- DM_rdata = mem[DM_addr] whenever DM_Rena=1, else 0. Pure combinational, no bypass: a write in the same cycle is visible from the next cycle.
- DM_Wena=1 writes DM_wdata to mem[DM_addr] at the edge.
- If DM_Wena and DM_Rena are both 1: the write is performed, DM_rdata returns the old value, and dm_err is set at the edge. dm_err is sticky until rst.
- A "CPU busy" cycle is any cycle with DM_Wena or DM_Rena high.
- Host port:
  - host_ready = host_valid & !cpu_busy & (state==IDLE).
  - An accepted write updates mem at the edge.
  - An accepted read drives host_rdata=mem[host_addr] and host_rvalid=1 in the next cycle.
  - host_rdata holds its value until the next accepted read.
- Sweep FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_start; counter is set to 0. clr_start is ignored outside IDLE.
  - In CLEAR, each cycle without CPU busy writes 0 to mem[counter] and increments counter. CPU-busy cycles hold counter.
  - After writing DEPTH-1: go to DONE, then IDLE the following cycle. clr_done=1 only in DONE.
  - clr_busy=1 in CLEAR and DONE.
  - CPU writes during CLEAR are performed. An address not yet swept is later overwritten with 0; an address already swept keeps the CPU data.
- Memory contents are not affected by rst.

## Timing
- Reset values: host_ready 0, host_rvalid 0, host_rdata 0, clr_busy 0, clr_done 0, dm_err 0, state IDLE, counter 0.
- rst during CLEAR aborts the sweep. Words already zeroed stay zeroed. No clr_done is issued.
- Latency:
  - CPU read: 0 cycles.
  - CPU write: visible from the next cycle.
  - Host read: 1 cycle after acceptance.
  - Full sweep: DEPTH + (CPU-busy cycles) cycles in CLEAR, plus 1 cycle in DONE.
- Only one array write happens per edge. Priority: CPU > sweep > host.
- The host must hold host_valid, host_we, host_addr and host_wdata stable until host_ready=1.
- Counter is AW+1 bits wide so the terminal compare at DEPTH-1 has no wrap ambiguity.
- DEPTH must be a power of two. Addresses wrap modulo DEPTH by truncation.

## Structure
- Package dmem_pkg holds:
  - the sweep state enum {IDLE, CLEAR, DONE}
  - default constants DMEM_DEPTH=2048, DMEM_AW=11, DMEM_DW=32
- Sub-module dmem_array holds the storage. It has:
  - one write port, with arbitration done in dmem_responder
  - one combinational read port for the CPU
  - one registered read port for the host
- The top level contains the arbiter, sweep FSM/counter, handshake logic and dm_err.

## Test plan
- CPU write 0xDEADBEEF at addr 5, then read with DM_Rena=1 the next cycle -> DM_rdata=0xDEADBEEF. With DM_Rena=0 -> DM_rdata=0.
- Host write 0x12345678 at addr 2047 while the CPU is idle -> host_ready=1 that cycle. Host read of addr 2047 -> host_rvalid pulses one cycle later with host_rdata=0x12345678.
- Host request held while the CPU is busy for 3 cycles -> host_ready stays 0 for those 3 cycles and is accepted on the first idle cycle. Memory ends holding the host data.
- Fill memory with nonzero data, then pulse clr_start with no CPU traffic -> clr_busy high for 2049 cycles, clr_done pulses once, all words read 0. Repeat with a CPU write to addr 10 at sweep counter 100: addr 10 keeps the CPU data. A CPU write to addr 1500 at counter 100 reads 0 afterward.
- Assert DM_Wena and DM_Rena together on addr 7 (old 0x1, new 0x2) -> DM_rdata=0x1 that cycle, mem[7]=0x2 afterward, dm_err=1 until rst.
- Assert rst at sweep counter 500 -> state IDLE, clr_busy=0, no clr_done. Addr 499 reads 0; addr 600 keeps its prior value.
